alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Sequential built-in self-test driver for the combinational ALU. It is the initiator side of the ALU interface.
- It generates operand pairs and operation codes, drives them into the ALU, and checks the ALU's out and zero against an internal golden model.
- It counts mismatches and records the first failing vector.
- It sits beside the ALU in the datapath test harness and on the SoC debug path. Its alu_* outputs are muxed onto the ALU inputs while busy is high.

Parameters:
- XLEN, 32, operand and result width. It must match the ALU's XLEN.
- NUM_VECTORS, 256, number of vectors per run. Minimum 8, maximum 65535.
- LFSR_SEED, 32'hACE1_2468, nonzero reload value of the operand LFSR.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request. Sampled only in IDLE or DONE.
- busy  output  1  high while a run is in progress (DRIVE/CHECK).
- done  output  1  high in DONE until the next accepted start.
- pass  output  1  done && fail_count==0.
- fail_count  output  16  number of failing vectors. Saturates at 16'hFFFF.
- first_fail_index  output  16  index of the first failing vector. Valid when fail_count!=0.
- first_fail_op  output  4  operation code of the first failing vector.
- alu_in_0  output  XLEN  ALU operand 0. Registered.
- alu_in_1  output  XLEN  ALU operand 1. Registered.
- alu_operation  output  4  ALU operation code, taken from the shared ALU codes header. Registered.
- alu_out  input  XLEN  ALU result.
- alu_zero  input  1  ALU zero flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - Cleared: busy, done, pass, fail_count, first_fail_index, first_fail_op, alu_in_0, alu_in_1, vector index.
  - alu_operation=ALU_AND. LFSR=LFSR_SEED.
  - Reset mid-run aborts immediately. No partial result is retained.
- State IDLE / DONE:
  - On a clk edge with start=1: clear fail_count and first_fail_*, reload the LFSR, set index=0, load vector 0 into alu_* registers, go to DRIVE.
  - done drops on that edge. Otherwise the state holds.
- State DRIVE: alu_* are stable and the ALU settles combinationally. The next edge goes to CHECK; alu_* stay unchanged.
- State CHECK:
  - On the leaving edge, compare alu_out against expected and alu_zero against (expected==0).
  - Either mismatch counts the vector as failed once.
  - On the first failure, capture index and op.
  - If index==NUM_VECTORS-1, go to DONE. Otherwise increment index, load the next vector, and go to DRIVE.
- Latency: done rises exactly 2*NUM_VECTORS edges after the edge that accepted start.
- start while busy is ignored.
- Operation sequence: index mod 4 selects ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, in that order.
- Operand sequence:
  - Vectors 0-3: in_0=0, in_1=0.
  - Vectors 4-7: in_0=all ones, in_1=1.
  - Vector 8 onward: the LFSR steps twice per vector; in_0=state after the first step, in_1=state after the second step.
  - LFSR: 32-bit Galois, right shift, xor mask 32'h8020_0003 when the shifted-out bit is 1. It is truncated to XLEN if XLEN<32.
- Golden model:
  - AND, OR, ADD modulo 2^XLEN.
  - SUB as in_0 + ~in_1 + 1 modulo 2^XLEN; no overflow flag.
- Determinism: repeated runs after a restart from DONE produce identical vectors and results.
- Saturation: fail_count holds at 16'hFFFF; first_fail_* are never overwritten after capture.

Test Plan:
- Reset values: assert rst_n=0 mid-run (during CHECK of vector 5) → on the same cycle busy=0, done=0, fail_count=0, alu_operation=ALU_AND, alu_in_*=0; after release, state is IDLE.
- Golden ALU, NUM_VECTORS=8, pulse start → busy high for 16 cycles; done=1 and pass=1 exactly 16 edges after acceptance; fail_count=0. Directed expectations: v4 AND=1; v5 OR=FFFFFFFF; v6 ADD=0 with zero=1; v7 SUB=FFFFFFFE.
- Fault injection, alu_zero stuck at 0, NUM_VECTORS=8 → fail_count=5 (vectors 0,1,2,3,6), first_fail_index=0, first_fail_op=ALU_AND, pass=0.
- Fault injection, alu_out bit 0 stuck at 0, NUM_VECTORS=8 → fail_count=2 (vectors 4,5), first_fail_index=4, first_fail_op=ALU_AND.
- Start held high for a whole run plus a second start pulse during busy → only one run executes; start still high in DONE starts a new run, with identical vector stream and results.
- NUM_VECTORS=256, golden ALU vs reference LFSR model in the bench → all 256 operand pairs match the model, pass=1, done at edge 512.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test initiator for the combinational ALU: drives a deterministic
// vector stream, checks out/zero against a golden model, and logs failures.
module alu_bist #(
    parameter int          XLEN        = 32,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     fail_count,
    output logic [15:0]     first_fail_index,
    output logic [3:0]      first_fail_op,
    output logic [XLEN-1:0] alu_in_0,
    output logic [XLEN-1:0] alu_in_1,
    output logic [3:0]      alu_operation,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero
);

    localparam logic [3:0]  ALU_AND    = 4'b0000;
    localparam logic [3:0]  ALU_OR     = 4'b0001;
    localparam logic [3:0]  ALU_ADD    = 4'b0010;
    localparam logic [3:0]  ALU_SUB    = 4'b0110;
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
    localparam logic [15:0] LAST_INDEX = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [15:0] index_reg;
    logic [31:0] lfsr_reg;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    // Next-vector generator, shared by the start path (vector 0) and the CHECK path.
    logic            accept;
    logic [15:0]     gen_index;
    logic [31:0]     gen_base;
    logic [31:0]     gen_step_1;
    logic [31:0]     gen_step_2;
    logic [31:0]     gen_lfsr;
    logic [XLEN-1:0] gen_in_0;
    logic [XLEN-1:0] gen_in_1;
    logic [3:0]      gen_op;

    assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign gen_index  = accept ? 16'd0 : index_reg + 16'd1;
    assign gen_base   = accept ? LFSR_SEED : lfsr_reg;
    assign gen_step_1 = lfsr_step(gen_base);
    assign gen_step_2 = lfsr_step(gen_step_1);

    always_comb begin
        gen_in_0 = '0;
        gen_in_1 = '0;
        gen_lfsr = gen_base;
        if (gen_index >= 16'd8) begin
            gen_in_0 = XLEN'(gen_step_1);
            gen_in_1 = XLEN'(gen_step_2);
            gen_lfsr = gen_step_2;
        end else if (gen_index[2]) begin
            gen_in_0 = '1;
            gen_in_1 = XLEN'(1);
        end
    end

    always_comb begin
        gen_op = ALU_AND;
        case (gen_index[1:0])
            2'd0: gen_op = ALU_AND;
            2'd1: gen_op = ALU_OR;
            2'd2: gen_op = ALU_ADD;
            2'd3: gen_op = ALU_SUB;
            default: gen_op = ALU_AND;
        endcase
    end

    // Golden model evaluated from the registered operands held during DRIVE/CHECK.
    logic [XLEN-1:0] expected;
    logic            vec_fail;
    logic [15:0]     fail_count_inc;

    always_comb begin
        expected = '0;
        case (alu_operation)
            ALU_AND: expected = alu_in_0 & alu_in_1;
            ALU_OR:  expected = alu_in_0 | alu_in_1;
            ALU_ADD: expected = alu_in_0 + alu_in_1;
            ALU_SUB: expected = alu_in_0 + ~alu_in_1 + XLEN'(1);
            default: expected = '0;
        endcase
    end

    assign vec_fail       = (alu_out != expected) || (alu_zero != (expected == '0));
    assign fail_count_inc = (fail_count == 16'hFFFF) ? fail_count : fail_count + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            index_reg        <= '0;
            lfsr_reg         <= LFSR_SEED;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_index <= '0;
            first_fail_op    <= '0;
            alu_in_0         <= '0;
            alu_in_1         <= '0;
            alu_operation    <= ALU_AND;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg        <= DRIVE;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        fail_count       <= '0;
                        first_fail_index <= '0;
                        first_fail_op    <= '0;
                        index_reg        <= gen_index;
                        lfsr_reg         <= gen_lfsr;
                        alu_in_0         <= gen_in_0;
                        alu_in_1         <= gen_in_1;
                        alu_operation    <= gen_op;
                    end
                end
                DRIVE: state_reg <= CHECK;
                CHECK: begin
                    if (vec_fail) begin
                        fail_count <= fail_count_inc;
                        if (fail_count == 16'd0) begin
                            first_fail_index <= index_reg;
                            first_fail_op    <= alu_operation;
                        end
                    end
                    if (index_reg == LAST_INDEX) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= !vec_fail && (fail_count == 16'd0);
                    end else begin
                        state_reg     <= DRIVE;
                        index_reg     <= gen_index;
                        lfsr_reg      <= gen_lfsr;
                        alu_in_0      <= gen_in_0;
                        alu_in_1      <= gen_in_1;
                        alu_operation <= gen_op;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: an 8-vector instance against a bench ALU with
// selectable faults, and a 256-vector instance against a reference LFSR stream.
module tb_alu_bist;

    localparam logic [3:0]  OP_AND = 4'b0000;
    localparam logic [3:0]  OP_OR  = 4'b0001;
    localparam logic [3:0]  OP_ADD = 4'b0010;
    localparam logic [3:0]  OP_SUB = 4'b0110;
    localparam logic [31:0] SEED   = 32'hACE1_2468;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int fault_mode = 0;  // 0 golden, 1 zero stuck at 0, 2 out bit 0 stuck at 0

    // Instance A: 8 vectors
    logic        a_rst_n, a_start, a_busy, a_done, a_pass;
    logic [15:0] a_fail_count, a_ffi;
    logic [3:0]  a_ffo, a_op;
    logic [31:0] a_in0, a_in1, a_out, a_true;
    logic        a_zero;

    // Instance B: 256 vectors
    logic        b_rst_n, b_start, b_busy, b_done, b_pass;
    logic [15:0] b_fail_count, b_ffi;
    logic [3:0]  b_ffo, b_op;
    logic [31:0] b_in0, b_in1, b_out;
    logic        b_zero;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            default: return 32'h0;
        endcase
    endfunction

    assign a_true = ref_alu(a_op, a_in0, a_in1);
    assign a_out  = (fault_mode == 2) ? (a_true & 32'hFFFF_FFFE) : a_true;
    assign a_zero = (fault_mode == 1) ? 1'b0 : (a_true == 32'h0);
    assign b_out  = ref_alu(b_op, b_in0, b_in1);
    assign b_zero = (b_out == 32'h0);

    alu_bist #(.XLEN(32), .NUM_VECTORS(8), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .pass(a_pass), .fail_count(a_fail_count), .first_fail_index(a_ffi),
        .first_fail_op(a_ffo), .alu_in_0(a_in0), .alu_in_1(a_in1),
        .alu_operation(a_op), .alu_out(a_out), .alu_zero(a_zero)
    );

    alu_bist #(.XLEN(32), .NUM_VECTORS(256), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .pass(b_pass), .fail_count(b_fail_count), .first_fail_index(b_ffi),
        .first_fail_op(b_ffo), .alu_in_0(b_in0), .alu_in_1(b_in1),
        .alu_operation(b_op), .alu_out(b_out), .alu_zero(b_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_op(input int k);
        case (k % 4)
            0:       return OP_AND;
            1:       return OP_OR;
            2:       return OP_ADD;
            default: return OP_SUB;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Accept a start on instance A; returns #1 after the accepting edge.
    task automatic start_a();
        @(negedge clk);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    logic [31:0] stream [2][8];

    // Walks the 8 vectors of a run from the accept edge to edge 16.
    task automatic body_a(input int run_id, input bit toggle_start);
        logic [31:0] dir_out [4];
        dir_out[0] = 32'h0000_0001;
        dir_out[1] = 32'hFFFF_FFFF;
        dir_out[2] = 32'h0000_0000;
        dir_out[3] = 32'hFFFF_FFFE;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("v%0d_in0", k), 64'(a_in0), (k < 4) ? 64'h0 : 64'hFFFF_FFFF);
            check($sformatf("v%0d_in1", k), 64'(a_in1), (k < 4) ? 64'h0 : 64'h1);
            check($sformatf("v%0d_op", k), 64'(a_op), 64'(exp_op(k)));
            check($sformatf("v%0d_busy", k), 64'(a_busy), 64'h1);
            stream[run_id][k] = a_out;
            if (k >= 4)
                check($sformatf("v%0d_out", k), 64'(a_out), 64'(dir_out[k-4]));
            if (k == 6)
                check("v6_zero", 64'(a_zero), 64'h1);
            if (toggle_start && k == 3) a_start = 1'b0;
            if (toggle_start && k == 5) a_start = 1'b1;
            tick();
            check($sformatf("v%0d_done_early", k), 64'(a_done), 64'h0);
            tick();
        end
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] e0, e1;

        a_rst_n = 1'b0; a_start = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0;
        tick(); tick();
        check("rst_busy", 64'(a_busy), 64'h0);
        check("rst_done", 64'(a_done), 64'h0);
        check("rst_pass", 64'(a_pass), 64'h0);
        check("rst_fail_count", 64'(a_fail_count), 64'h0);
        check("rst_op", 64'(a_op), 64'(OP_AND));
        check("rst_in0", 64'(a_in0), 64'h0);
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick(); tick();
        check("idle_busy", 64'(a_busy), 64'h0);

        // Golden run, 8 vectors
        fault_mode = 0;
        start_a();
        body_a(0, 1'b0);
        check("gold_done", 64'(a_done), 64'h1);
        check("gold_pass", 64'(a_pass), 64'h1);
        check("gold_busy", 64'(a_busy), 64'h0);
        check("gold_fail_count", 64'(a_fail_count), 64'h0);

        // alu_zero stuck at 0
        fault_mode = 1;
        start_a();
        for (int i = 0; i < 16; i++) tick();
        check("fz_done", 64'(a_done), 64'h1);
        check("fz_fail_count", 64'(a_fail_count), 64'd5);
        check("fz_first_index", 64'(a_ffi), 64'd0);
        check("fz_first_op", 64'(a_ffo), 64'(OP_AND));
        check("fz_pass", 64'(a_pass), 64'h0);

        // alu_out bit 0 stuck at 0
        fault_mode = 2;
        start_a();
        for (int i = 0; i < 16; i++) tick();
        check("fb_done", 64'(a_done), 64'h1);
        check("fb_fail_count", 64'(a_fail_count), 64'd2);
        check("fb_first_index", 64'(a_ffi), 64'd4);
        check("fb_first_op", 64'(a_ffo), 64'(OP_AND));
        check("fb_pass", 64'(a_pass), 64'h0);

        // start held high plus a re-pulse during busy: one run, then restart from DONE
        fault_mode = 0;
        @(negedge clk);
        a_start = 1'b1;
        tick();
        body_a(0, 1'b1);
        check("held_done", 64'(a_done), 64'h1);
        check("held_pass", 64'(a_pass), 64'h1);
        tick();
        a_start = 1'b0;
        check("restart_done", 64'(a_done), 64'h0);
        check("restart_busy", 64'(a_busy), 64'h1);
        body_a(1, 1'b0);
        check("restart2_done", 64'(a_done), 64'h1);
        check("restart2_pass", 64'(a_pass), 64'h1);
        for (int k = 0; k < 8; k++)
            check($sformatf("repeat_v%0d_out", k), 64'(stream[1][k]), 64'(stream[0][k]));

        // Reset during CHECK of vector 5
        fault_mode = 1;
        start_a();
        for (int i = 0; i < 11; i++) tick();
        check("mid_fail_count", 64'(a_fail_count), 64'd4);
        check("mid_in0", 64'(a_in0), 64'hFFFF_FFFF);
        a_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(a_busy), 64'h0);
        check("mid_rst_done", 64'(a_done), 64'h0);
        check("mid_rst_fail_count", 64'(a_fail_count), 64'h0);
        check("mid_rst_op", 64'(a_op), 64'(OP_AND));
        check("mid_rst_in0", 64'(a_in0), 64'h0);
        check("mid_rst_in1", 64'(a_in1), 64'h0);
        @(negedge clk);
        a_rst_n = 1'b1;
        tick(); tick(); tick();
        check("post_rst_busy", 64'(a_busy), 64'h0);
        check("post_rst_done", 64'(a_done), 64'h0);
        fault_mode = 0;

        // 256-vector run against the reference LFSR stream
        m = SEED;
        @(negedge clk);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (k < 4) begin
                e0 = 32'h0; e1 = 32'h0;
            end else if (k < 8) begin
                e0 = 32'hFFFF_FFFF; e1 = 32'h1;
            end else begin
                m = lfsr_next(m); e0 = m;
                m = lfsr_next(m); e1 = m;
            end
            check($sformatf("b_v%0d_in0", k), 64'(b_in0), 64'(e0));
            check($sformatf("b_v%0d_in1", k), 64'(b_in1), 64'(e1));
            check($sformatf("b_v%0d_op", k), 64'(b_op), 64'(exp_op(k)));
            tick();
            if (k == 255) check("b_done_at_511", 64'(b_done), 64'h0);
            tick();
        end
        check("b_done_at_512", 64'(b_done), 64'h1);
        check("b_pass", 64'(b_pass), 64'h1);
        check("b_fail_count", 64'(b_fail_count), 64'h0);
        check("b_busy", 64'(b_busy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
